// File: rtl/exception_ctrl_if.sv
// Pipeline/CP0/fetch-side signal bundle for the exception sequencer.
// master: the pipeline-side driver of MEM-stage info, CP0 EPC and fetch ack.
// slave : the sequencer itself.
interface exception_ctrl_if;
  // MEM-stage request side
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_bd;
  logic        exc_adel_if;
  logic        exc_ri;
  logic        exc_ov;
  logic        exc_sys;
  logic        exc_bp;
  logic        exc_adel_d;
  logic        exc_ades;
  logic [31:0] mem_badvaddr;
  logic        mem_eret;
  logic [31:0] cp0_epc_i;
  // fetch handshake
  logic        pc_ack;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // CP0 event outputs
  logic        cp0_exc_we;
  logic [31:0] cp0_epc_o;
  logic [4:0]  cp0_exccode_o;
  logic        cp0_bd_o;
  logic [31:0] cp0_badvaddr_o;
  logic        cp0_eret_o;
  logic        busy;

  modport master (
    output mem_valid, mem_pc, mem_bd, exc_adel_if, exc_ri, exc_ov, exc_sys,
           exc_bp, exc_adel_d, exc_ades, mem_badvaddr, mem_eret, cp0_epc_i,
           pc_ack,
    input  flush, redirect_valid, redirect_pc, cp0_exc_we, cp0_epc_o,
           cp0_exccode_o, cp0_bd_o, cp0_badvaddr_o, cp0_eret_o, busy
  );

  modport slave (
    input  mem_valid, mem_pc, mem_bd, exc_adel_if, exc_ri, exc_ov, exc_sys,
           exc_bp, exc_adel_d, exc_ades, mem_badvaddr, mem_eret, cp0_epc_i,
           pc_ack,
    output flush, redirect_valid, redirect_pc, cp0_exc_we, cp0_epc_o,
           cp0_exccode_o, cp0_bd_o, cp0_badvaddr_o, cp0_eret_o, busy
  );
endinterface

// File: rtl/exception_ctrl.sv
// Exception / ERET sequencer: prioritises MEM-stage exception flags, issues a
// one-cycle CP0 commit (or ERET pulse), flushes the pipeline for FLUSH_CYCLES
// and then holds a PC redirect until fetch acknowledges it.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  exception_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  // Flag vector order, highest priority first:
  // adel_if, ri, ov, sys, bp, adel_d, ades
  function automatic logic [4:0] exc_code_f(input logic [6:0] f);
    logic [4:0] code;
    if (f[6])      code = 5'd4;
    else if (f[5]) code = 5'd10;
    else if (f[4]) code = 5'd12;
    else if (f[3]) code = 5'd8;
    else if (f[2]) code = 5'd9;
    else if (f[1]) code = 5'd4;
    else if (f[0]) code = 5'd5;
    else           code = 5'd0;
    return code;
  endfunction

  // BadVAddr follows the winning exception only.
  function automatic logic [31:0] badvaddr_f(input logic [6:0] f,
                                             input logic [31:0] pc,
                                             input logic [31:0] dva);
    logic [31:0] v;
    if (f[6])                v = pc;
    else if (f[5:2] != 4'd0) v = 32'd0;
    else if (f[1] || f[0])   v = dva;
    else                     v = 32'd0;
    return v;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;

  logic        flush_q, flush_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rpc_q, rpc_d;
  logic        exc_we_q, exc_we_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic [31:0] bva_q, bva_d;
  logic        eret_q, eret_d;
  logic        busy_q, busy_d;

  logic [6:0]  exc_flags_s;
  logic        exc_any_s;
  logic        accept_s;

  assign exc_flags_s = {bus.exc_adel_if, bus.exc_ri, bus.exc_ov, bus.exc_sys,
                        bus.exc_bp, bus.exc_adel_d, bus.exc_ades};
  assign exc_any_s   = |exc_flags_s;
  // Inputs only matter in IDLE; anything arriving while busy is dropped.
  assign accept_s    = (state_q == IDLE) && bus.mem_valid &&
                       (exc_any_s || bus.mem_eret);

  // State register: FSM state, flush down-counter and latched redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      target_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  // Next-state logic: accept -> FLUSH (counted) -> REDIRECT until pc_ack.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d  = FLUSH;
          cnt_d    = FLUSH_INIT;
          target_d = exc_any_s ? EXC_VECTOR : bus.cp0_epc_i;
        end else begin
          state_d  = IDLE;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = REDIRECT;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      REDIRECT: begin
        if (bus.pc_ack) begin
          state_d = IDLE;
        end else begin
          state_d = REDIRECT;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = 4'd0;
        target_d = 32'd0;
      end
    endcase
  end

  // Output decode: next values of every registered output, aligned with state_d.
  always_comb begin
    flush_d  = (state_d == FLUSH);
    rvalid_d = (state_d == REDIRECT);
    rpc_d    = (state_d == REDIRECT) ? target_d : 32'd0;
    busy_d   = (state_d != IDLE);
    exc_we_d = accept_s && exc_any_s;
    eret_d   = accept_s && !exc_any_s;
    if (accept_s && exc_any_s) begin
      epc_d  = bus.mem_bd ? (bus.mem_pc - 32'd4) : bus.mem_pc;
      code_d = exc_code_f(exc_flags_s);
      bd_d   = bus.mem_bd;
      bva_d  = badvaddr_f(exc_flags_s, bus.mem_pc, bus.mem_badvaddr);
    end else begin
      epc_d  = epc_q;
      code_d = code_q;
      bd_d   = bd_q;
      bva_d  = bva_q;
    end
  end

  // Output registers: every output is a flop cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rpc_q    <= 32'd0;
      exc_we_q <= 1'b0;
      epc_q    <= 32'd0;
      code_q   <= 5'd0;
      bd_q     <= 1'b0;
      bva_q    <= 32'd0;
      eret_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      flush_q  <= flush_d;
      rvalid_q <= rvalid_d;
      rpc_q    <= rpc_d;
      exc_we_q <= exc_we_d;
      epc_q    <= epc_d;
      code_q   <= code_d;
      bd_q     <= bd_d;
      bva_q    <= bva_d;
      eret_q   <= eret_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.flush          = flush_q;
  assign bus.redirect_valid = rvalid_q;
  assign bus.redirect_pc    = rpc_q;
  assign bus.cp0_exc_we     = exc_we_q;
  assign bus.cp0_epc_o      = epc_q;
  assign bus.cp0_exccode_o  = code_q;
  assign bus.cp0_bd_o       = bd_q;
  assign bus.cp0_badvaddr_o = bva_q;
  assign bus.cp0_eret_o     = eret_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: stimulus pushes expected CP0 events and
// redirect targets; a negedge monitor pops and compares whenever the DUT
// presents a CP0 pulse or a redirect handshake.
module tb_exception_ctrl;

  localparam int          FC  = 2;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic clk;
  logic rst;
  exception_ctrl_if bus();

  exception_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        is_exc;
    logic [31:0] epc;
    logic [4:0]  code;
    logic        bd;
    logic [31:0] bva;
  } cp0_exp_t;

  cp0_exp_t    cp0_q[$];
  logic [31:0] rd_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [106:0] all_outs();
    return {bus.flush, bus.redirect_valid, bus.redirect_pc, bus.cp0_exc_we,
            bus.cp0_epc_o, bus.cp0_exccode_o, bus.cp0_bd_o, bus.cp0_badvaddr_o,
            bus.cp0_eret_o, bus.busy};
  endfunction

  task automatic clear_inputs();
    bus.mem_valid    = 1'b0;
    bus.mem_pc       = 32'd0;
    bus.mem_bd       = 1'b0;
    {bus.exc_adel_if, bus.exc_ri, bus.exc_ov, bus.exc_sys,
     bus.exc_bp, bus.exc_adel_d, bus.exc_ades} = 7'd0;
    bus.mem_badvaddr = 32'd0;
    bus.mem_eret     = 1'b0;
    bus.cp0_epc_i    = 32'd0;
  endtask

  // Monitor: pop and compare on every CP0 pulse and every redirect handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cp0_exc_we || bus.cp0_eret_o) begin
        if (cp0_q.size() == 0) begin
          check("cp0_unexpected_pulse", 128'({bus.cp0_exc_we, bus.cp0_eret_o}), 128'(2'b00));
        end else begin
          cp0_exp_t e;
          e = cp0_q.pop_front();
          check("cp0_exc_we", 128'(bus.cp0_exc_we), 128'(e.is_exc));
          check("cp0_eret", 128'(bus.cp0_eret_o), 128'(!e.is_exc));
          if (e.is_exc) begin
            check("cp0_epc", 128'(bus.cp0_epc_o), 128'(e.epc));
            check("cp0_code", 128'(bus.cp0_exccode_o), 128'(e.code));
            check("cp0_bd", 128'(bus.cp0_bd_o), 128'(e.bd));
            check("cp0_badvaddr", 128'(bus.cp0_badvaddr_o), 128'(e.bva));
          end
        end
      end
      if (bus.redirect_valid && bus.pc_ack) begin
        if (rd_q.size() == 0) begin
          check("redirect_unexpected", 128'(bus.redirect_valid), 128'(1'b0));
        end else begin
          check("redirect_pc", 128'(bus.redirect_pc), 128'(rd_q.pop_front()));
        end
      end
    end
  end

  // Issue one request in the current cycle (called at posedge+1) and walk the
  // full FLUSH/REDIRECT sequence; returns at posedge+1 of the first IDLE cycle.
  task automatic do_req(input logic [6:0] fl, input logic er, input logic [31:0] pc,
                        input logic bd, input logic [31:0] bva, input logic [31:0] epci,
                        input logic exp_exc, input logic [31:0] exp_epc, input logic [4:0] exp_code,
                        input logic exp_bd, input logic [31:0] exp_bva, input logic [31:0] exp_tgt,
                        input int ack_delay, input logic poke_busy);
    cp0_exp_t e;
    e.is_exc = exp_exc; e.epc = exp_epc; e.code = exp_code; e.bd = exp_bd; e.bva = exp_bva;
    cp0_q.push_back(e);
    rd_q.push_back(exp_tgt);
    bus.mem_valid = 1'b1; bus.mem_pc = pc; bus.mem_bd = bd; bus.mem_badvaddr = bva;
    {bus.exc_adel_if, bus.exc_ri, bus.exc_ov, bus.exc_sys,
     bus.exc_bp, bus.exc_adel_d, bus.exc_ades} = fl;
    bus.mem_eret = er; bus.cp0_epc_i = epci;
    @(posedge clk); #1; clear_inputs();
    check("flush_t1", 128'({bus.flush, bus.busy}), 128'(2'b11));
    if (poke_busy) begin
      bus.mem_valid = 1'b1; bus.exc_sys = 1'b1; bus.mem_pc = 32'h00000BAD;
      bus.mem_eret = 1'b1; bus.cp0_epc_i = 32'h0BAD0BAD;
    end
    for (int i = 1; i < FC; i++) begin
      @(posedge clk); #1; clear_inputs();
      check("flush_mid", 128'({bus.flush, bus.redirect_valid}), 128'(2'b10));
    end
    @(posedge clk); #1; clear_inputs();
    check("redirect_start", 128'({bus.flush, bus.redirect_valid, bus.redirect_pc}),
          128'({1'b0, 1'b1, exp_tgt}));
    repeat (ack_delay) begin
      @(posedge clk); #1;
    end
    check("redirect_held", 128'({bus.redirect_valid, bus.redirect_pc}), 128'({1'b1, exp_tgt}));
    bus.pc_ack = 1'b1;
    @(posedge clk); #1;
    bus.pc_ack = 1'b0;
    check("idle_after_ack", 128'({bus.busy, bus.redirect_valid, bus.redirect_pc}), 128'(34'd0));
    if (exp_exc) check("cp0_epc_hold", 128'(bus.cp0_epc_o), 128'(exp_epc));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    rst = 1'b1;
    bus.pc_ack = 1'b0;
    clear_inputs();
    #12;
    check("reset_outputs", 128'(all_outs()), 128'(107'd0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // flags: {adel_if, ri, ov, sys, bp, adel_d, ades}
    do_req(7'b0001000, 1'b0, 32'h00400010, 1'b0, 32'd0, 32'd0,
           1'b1, 32'h00400010, 5'd8, 1'b0, 32'd0, VEC, 2, 1'b0);
    do_req(7'b0010000, 1'b0, 32'h00400024, 1'b1, 32'd0, 32'd0,
           1'b1, 32'h00400020, 5'd12, 1'b1, 32'd0, VEC, 0, 1'b0);
    do_req(7'b0010000, 1'b0, 32'h00000000, 1'b1, 32'd0, 32'd0,
           1'b1, 32'hFFFFFFFC, 5'd12, 1'b1, 32'd0, VEC, 1, 1'b0);
    do_req(7'b0101001, 1'b0, 32'h00400030, 1'b0, 32'h12345678, 32'd0,
           1'b1, 32'h00400030, 5'd10, 1'b0, 32'd0, VEC, 0, 1'b0);
    do_req(7'b1010000, 1'b0, 32'h00400001, 1'b0, 32'hDEADBEEF, 32'd0,
           1'b1, 32'h00400001, 5'd4, 1'b0, 32'h00400001, VEC, 0, 1'b0);
    do_req(7'b0000001, 1'b0, 32'h00400040, 1'b0, 32'h10010003, 32'd0,
           1'b1, 32'h00400040, 5'd5, 1'b0, 32'h10010003, VEC, 0, 1'b0);
    do_req(7'b0000000, 1'b1, 32'h00400050, 1'b0, 32'd0, 32'h00400100,
           1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'h00400100, 3, 1'b0);
    do_req(7'b0000100, 1'b1, 32'h00400200, 1'b0, 32'd0, 32'h00400100,
           1'b1, 32'h00400200, 5'd9, 1'b0, 32'd0, VEC, 0, 1'b0);
    do_req(7'b0000010, 1'b0, 32'h00400300, 1'b1, 32'h00000003, 32'd0,
           1'b1, 32'h004002FC, 5'd4, 1'b1, 32'h00000003, VEC, 1, 1'b1);

    // Flags without mem_valid are ignored.
    bus.exc_sys = 1'b1; bus.mem_pc = 32'h00400400;
    repeat (3) begin
      @(posedge clk); #1;
      check("novalid_idle", 128'({bus.busy, bus.flush}), 128'(2'b00));
    end
    clear_inputs();

    // Reset in REDIRECT: CP0 pulse expected, redirect is killed.
    begin
      cp0_exp_t e;
      e.is_exc = 1'b1; e.epc = 32'h00400500; e.code = 5'd8; e.bd = 1'b0; e.bva = 32'd0;
      cp0_q.push_back(e);
    end
    bus.mem_valid = 1'b1; bus.exc_sys = 1'b1; bus.mem_pc = 32'h00400500;
    @(posedge clk); #1; clear_inputs();
    repeat (FC) begin
      @(posedge clk); #1;
    end
    check("pre_reset_redirect", 128'({bus.redirect_valid, bus.redirect_pc}), 128'({1'b1, VEC}));
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", 128'(all_outs()), 128'(107'd0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", 128'(all_outs()), 128'(107'd0));

    do_req(7'b0001000, 1'b0, 32'h00400600, 1'b0, 32'd0, 32'd0,
           1'b1, 32'h00400600, 5'd8, 1'b0, 32'd0, VEC, 0, 1'b0);

    repeat (3) @(posedge clk);
    check("cp0_queue_drained", 128'(cp0_q.size()), 128'(0));
    check("redirect_queue_drained", 128'(rd_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
